sparse_psum_accum: RTL
======================

// Module: sparse_psum_accum
// PURPOSE
//   Multi-channel partial-sum accumulator behind the sparse PE array. Takes a bundle of PE_OUT
//   products, each tagged with signed (row,col) output coordinates, and scatter-adds them into an
//   NUM_CH x OUT_H x OUT_W feature buffer. On flush it streams the buffer out with valid/ready and clears it.
// PARAMETERS
//   DW        16  product / accumulator word width (signed, two's complement)
//   CW        8   coordinate field width (signed)
//   PE_OUT    16  products per input bundle
//   OUT_H     5   output rows
//   OUT_W     5   output columns
//   NUM_CH    4   output channels held in buffer
//   CH_W      2   channel index width, $clog2(NUM_CH)
// PORTS
//   clk       in   1             single clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   in_valid  in   1             bundle valid
//   in_ready  out  1             bundle accepted when in_valid & in_ready
//   in_ch     in   CH_W          target channel of bundle
//   in_data   in   PE_OUT*DW     products, entry k at [k*DW +: DW]
//   in_rows   in   PE_OUT*CW     signed row of entry k
//   in_cols   in   PE_OUT*CW     signed col of entry k
//   flush     in   1             one-cycle pulse: request drain
//   out_valid out  1             drain word valid
//   out_ready in   1             drain word consumed when out_valid & out_ready
//   out_data  out  DW            accumulated word
//   out_ch    out  CH_W          channel of out_data
//   out_last  out  1             final word of drain
//   busy      out  1             state != IDLE or flush pending
// BEHAVIOUR
//   Reset: state IDLE, buffer all 0, in_ready 1, out_valid/out_last/busy 0, out_data/out_ch 0, counters 0.
//   FSM IDLE -> ACCUM on handshake; ACCUM -> IDLE after entry PE_OUT-1; IDLE -> DRAIN when flush pending
//     and no handshake that cycle; DRAIN -> IDLE after out_last handshake.
//   in_ready = (state==IDLE) & ~flush_pending. Bundle fields registered at handshake.
//   ACCUM: entry k processed in cycle k (k=0..PE_OUT-1); fixed PE_OUT cycles per bundle, skipped entries included.
//   Entry valid iff 0<=row<OUT_H and 0<=col<OUT_W (signed compare); else no buffer write.
//   Address = (ch*OUT_H + row)*OUT_W + col; buf[addr] <= buf[addr] + data (DW-bit, see CONFIGURATION).
//   Duplicate coordinates within a bundle accumulate correctly (serial read-modify-write, no hazard).
//   flush pulse sets flush_pending (in any state); pulse during ACCUM is held until bundle finishes.
//   Flush and in_valid both high in IDLE with nothing pending: bundle handshake wins, flush stays pending.
//   DRAIN: order ch 0..NUM_CH-1, within ch addr row-major 0..OUT_H*OUT_W-1; out_valid held with stable
//     out_data/out_ch under backpressure; each word zeroed in buffer on its handshake; out_last on final word.
//   flush_pending cleared on DRAIN entry; flush during DRAIN re-pends a second drain (all zeros).
//   Reset asserted mid-ACCUM/DRAIN: immediate return to reset state, buffer cleared, partial drain discarded.
// CONFIGURATION
//   SPARSE_PSUM_SAT_EN defined: add saturates to [-2^(DW-1), 2^(DW-1)-1].
//   Not defined: two's-complement wrap-around (modulo 2^DW).
// STRUCTURE
//   Package sparse_cnn_pkg: DW, CW, OUT_H, OUT_W, NUM_CH defaults; state enum {IDLE,ACCUM,DRAIN};
//     function addr_of(ch,row,col); constant OUT_SIZE = OUT_H*OUT_W.
//   Sub-module psum_lane_add: combinational bounds check + (saturating) add of one entry; instanced once.
// TESTING
//   Bundle ch=0, entry0 (row1,col2,data=5), others row=-1 -> after flush, word 7 of ch0 = 5, all other words 0.
//   Two bundles ch=1 same coord (0,0) data 3 and -10 -> drain word 25 (ch1 addr0) = -7.
//   One bundle, entries 0..3 all at (4,4) data 100 -> ch0 addr24 = 400; in_ready low exactly PE_OUT cycles.
//   Out-of-range (5,0),(0,5),(-1,3),(2,-128) with data 9 -> whole buffer stays 0; no X on out_data.
//   SAT_EN, DW=16: 0x7FF0 + 0x0020 at (0,0) -> 0x7FFF; without macro -> 0x8010.
//   Drain with out_ready toggling 1/0, flush during drain, rst_n low at word 30 -> words stable under stall,
//     out_last only on word NUM_CH*25-1, second drain all 0, reset clears buffer and out_valid in same cycle.

Source files
------------

// File: rtl/sparse_cnn_pkg.sv
// Shared constants, FSM state type and buffer addressing for the sparse partial-sum accumulator.
// Word/coordinate widths and the feature-buffer geometry all live here.
package sparse_cnn_pkg;

  localparam int DW        = 16;
  localparam int CW        = 8;
  localparam int PE_OUT    = 16;
  localparam int OUT_H     = 5;
  localparam int OUT_W     = 5;
  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;

  localparam int OUT_SIZE  = OUT_H * OUT_W;
  localparam int BUF_DEPTH = NUM_CH * OUT_SIZE;
  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int IDX_W     = $clog2(PE_OUT);
  localparam int POS_W     = $clog2(OUT_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Only meaningful for in-range coordinates; callers gate the write on the bounds check.
  function automatic logic [AW-1:0] addr_of(input logic [CH_W-1:0] ch,
                                            input logic [CW-1:0]   row,
                                            input logic [CW-1:0]   col);
    int a;
    a = (int'(ch) * OUT_H + int'(row)) * OUT_W + int'(col);
    return AW'(a);
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// One accumulation lane: signed bounds check of an entry's (row,col) and the accumulate add.
// SPARSE_PSUM_SAT_EN selects a saturating add; otherwise the add wraps modulo 2^DW.
module psum_lane_add
  import sparse_cnn_pkg::*;
(
  input  logic [CW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] acc_i,
  output logic          hit_o,
  output logic [DW-1:0] sum_o
);

  localparam logic signed [CW-1:0] ROW_LIM = CW'(OUT_H);
  localparam logic signed [CW-1:0] COL_LIM = CW'(OUT_W);

  logic signed [CW-1:0] row_s;
  logic signed [CW-1:0] col_s;

  assign row_s = $signed(row_i);
  assign col_s = $signed(col_i);

  // Sign bit clear gives the lower bound; the upper bound is a signed compare.
  assign hit_o = !row_i[CW-1] && (row_s < ROW_LIM) &&
                 !col_i[CW-1] && (col_s < COL_LIM);

`ifdef SPARSE_PSUM_SAT_EN
  logic [DW:0] wide;

  assign wide = {acc_i[DW-1], acc_i} + {data_i[DW-1], data_i};

  always_comb begin
    sum_o = wide[DW-1:0];
    if (wide[DW] != wide[DW-1]) begin
      sum_o = wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign sum_o = acc_i + data_i;
`endif

endmodule

// File: rtl/sparse_psum_accum.sv
// Scatter-add accumulator: serially folds PE_OUT tagged products into an NUM_CH x OUT_H x OUT_W
// buffer, then drains and clears it on flush. Optional SPARSE_PSUM_SAT_EN makes the adds saturate.
module sparse_psum_accum
  import sparse_cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [PE_OUT*DW-1:0] in_data,
  input  logic [PE_OUT*CW-1:0] in_rows,
  input  logic [PE_OUT*CW-1:0] in_cols,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_DEPTH - 1);

  state_t               state_q, state_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [PE_OUT*DW-1:0] data_q, data_d;
  logic [PE_OUT*CW-1:0] rows_q, rows_d;
  logic [PE_OUT*CW-1:0] cols_q, cols_d;
  logic [CH_W-1:0]      dr_ch_q, dr_ch_d;
  logic [POS_W-1:0]     dr_pos_q, dr_pos_d;

  logic [DW-1:0]        mem_q [BUF_DEPTH];

  logic                 in_hs, out_hs;
  logic [CW-1:0]        ent_row, ent_col;
  logic [DW-1:0]        ent_data;
  logic [AW-1:0]        acc_addr, acc_rd_addr, dr_addr;
  logic [DW-1:0]        acc_rd;
  logic                 lane_hit;
  logic [DW-1:0]        lane_sum;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;

  assign in_ready  = (state_q == IDLE) && !flush_pend_q;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state_q == DRAIN);
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state_q != IDLE) || flush_pend_q;

  assign ent_row   = rows_q[idx_q*CW +: CW];
  assign ent_col   = cols_q[idx_q*CW +: CW];
  assign ent_data  = data_q[idx_q*DW +: DW];
  assign acc_addr  = addr_of(ch_q, ent_row, ent_col);
  // Skipped entries can form addresses past the buffer; keep the read port in range anyway.
  assign acc_rd_addr = (acc_addr <= LAST_ADDR) ? acc_addr : '0;
  assign acc_rd      = mem_q[acc_rd_addr];

  assign dr_addr   = AW'(int'(dr_ch_q) * OUT_SIZE + int'(dr_pos_q));
  assign out_data  = out_valid ? mem_q[dr_addr] : '0;
  assign out_ch    = out_valid ? dr_ch_q : '0;
  assign out_last  = out_valid && (dr_ch_q == CH_W'(NUM_CH - 1)) &&
                     (dr_pos_q == POS_W'(OUT_SIZE - 1));

  psum_lane_add u_lane (
    .row_i  (ent_row),
    .col_i  (ent_col),
    .data_i (ent_data),
    .acc_i  (acc_rd),
    .hit_o  (lane_hit),
    .sum_o  (lane_sum)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush;
    idx_d        = idx_q;
    ch_d         = ch_q;
    data_d       = data_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    dr_ch_d      = dr_ch_q;
    dr_pos_d     = dr_pos_q;
    wr_en        = 1'b0;
    wr_addr      = acc_addr;
    wr_data      = lane_sum;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = ACCUM;
          idx_d   = '0;
          ch_d    = in_ch;
          data_d  = in_data;
          rows_d  = in_rows;
          cols_d  = in_cols;
        end else if (flush_pend_q) begin
          // A flush arriving on the entry cycle itself queues the next drain.
          state_d      = DRAIN;
          flush_pend_d = flush;
          dr_ch_d      = '0;
          dr_pos_d     = '0;
        end
      end
      ACCUM: begin
        wr_en = lane_hit;
        if (idx_q == IDX_W'(PE_OUT - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (out_hs) begin
          wr_en   = 1'b1;
          wr_addr = dr_addr;
          wr_data = '0;
          if (out_last) begin
            state_d = IDLE;
          end else if (dr_pos_q == POS_W'(OUT_SIZE - 1)) begin
            dr_pos_d = '0;
            dr_ch_d  = dr_ch_q + CH_W'(1);
          end else begin
            dr_pos_d = dr_pos_q + POS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      idx_q        <= '0;
      ch_q         <= '0;
      data_q       <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      dr_ch_q      <= '0;
      dr_pos_q     <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      idx_q        <= idx_d;
      ch_q         <= ch_d;
      data_q       <= data_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      dr_ch_q      <= dr_ch_d;
      dr_pos_q     <= dr_pos_d;
    end
  end

  // Register array rather than block RAM: reset must clear every word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule
